// File: rtl/dpram_arb_pkg.sv
// Purpose     : shared types/constants for the dual-requester DPRAM port arbiter.
// Latency     : n/a (declarations only).
// Backpressure: n/a.
package dpram_arb_pkg;

  // Arbiter FSM: free arbitration, or a burst locked to requester 0 / 1.
  typedef enum logic [1:0] {
    IDLE  = 2'd0,
    LOCK0 = 2'd1,
    LOCK1 = 2'd2
  } arb_state_e;

  // Width of the optional statistics counters.
  localparam int STATS_W = 32;

  // Locked-burst beat counter width; MAX_LOCK is limited to 1..255.
  localparam int LOCK_CNT_W = 8;

endpackage

// File: rtl/dpram_rr_pick.sv
// Purpose     : 2-way round-robin pick between two valids given the last winner.
// Latency     : combinational.
// Backpressure: none; picks are one-hot or zero.
// Ports       : valid0/valid1 in, last_grant in (1 = requester 1 won last),
//               pick0/pick1 out.
module dpram_rr_pick (
  input  logic valid0,
  input  logic valid1,
  input  logic last_grant,
  output logic pick0,
  output logic pick1
);

  // A lone valid always wins; on a tie the requester that did not win last goes.
  assign pick0 = valid0 & (~valid1 | last_grant);
  assign pick1 = valid1 & (~valid0 | ~last_grant);

endmodule

// File: rtl/dpram_port_arbiter.sv
// Purpose     : arbitrates two valid/ready requesters onto one 1-cycle-latency RAM port,
//               with round-robin fairness and optional locked bursts.
// Latency     : beat drives the RAM in the accept cycle; read response one cycle later.
// Backpressure: reqN_ready from arbiter state and valids only; responses cannot stall.
// Ports       : clock/reset (async, active-high); req0_*/req1_* request channels;
//               resp0_*/resp1_* read responses; ram_* single RAM port.
// Option      : DPRAM_ARB_STATS_EN adds stat_grant0/stat_grant1/stat_stall counters.
module dpram_port_arbiter
  import dpram_arb_pkg::*;
#(
  parameter int DATA_WIDTH  = 32,
  parameter int NUM_ENTRIES = 2048,
  parameter int ADDR_WIDTH  = $clog2(NUM_ENTRIES),
  parameter int MAX_LOCK    = 16
) (
  input  logic                  clock,
  input  logic                  reset,
  input  logic                  req0_valid,
  output logic                  req0_ready,
  input  logic                  req0_we,
  input  logic                  req0_lock,
  input  logic [ADDR_WIDTH-1:0] req0_addr,
  input  logic [DATA_WIDTH-1:0] req0_wdata,
  input  logic                  req1_valid,
  output logic                  req1_ready,
  input  logic                  req1_we,
  input  logic                  req1_lock,
  input  logic [ADDR_WIDTH-1:0] req1_addr,
  input  logic [DATA_WIDTH-1:0] req1_wdata,
  output logic                  resp0_valid,
  output logic [DATA_WIDTH-1:0] resp0_data,
  output logic                  resp1_valid,
  output logic [DATA_WIDTH-1:0] resp1_data,
  output logic [ADDR_WIDTH-1:0] ram_addr,
  output logic                  ram_we,
  output logic [DATA_WIDTH-1:0] ram_din,
  input  logic [DATA_WIDTH-1:0] ram_dout
`ifdef DPRAM_ARB_STATS_EN
  ,
  output logic [STATS_W-1:0]    stat_grant0,
  output logic [STATS_W-1:0]    stat_grant1,
  output logic [STATS_W-1:0]    stat_stall
`endif
);

  localparam logic [LOCK_CNT_W-1:0] MAX_LOCK_C = LOCK_CNT_W'(MAX_LOCK);

  arb_state_e            state_q, state_d;
  logic                  last_grant_q, last_grant_d;
  logic [LOCK_CNT_W-1:0] cnt_q, cnt_d;
  logic [1:0]            resp_q, resp_d;   // bit N: read from requester N in flight

  logic rr_pick0, rr_pick1;
  logic gnt0, gnt1, beat_lock;
  logic [LOCK_CNT_W-1:0] cnt_inc;

  dpram_rr_pick u_rr_pick (
    .valid0     (req0_valid),
    .valid1     (req1_valid),
    .last_grant (last_grant_q),
    .pick0      (rr_pick0),
    .pick1      (rr_pick1)
  );

  // Grant: round-robin when idle, only the owner while locked, nothing in reset.
  always_comb begin
    gnt0 = 1'b0;
    gnt1 = 1'b0;
    unique case (state_q)
      IDLE: begin
        gnt0 = rr_pick0;
        gnt1 = rr_pick1;
      end
      LOCK0:   gnt0 = req0_valid;
      LOCK1:   gnt1 = req1_valid;
      default: ;
    endcase
    if (reset) begin
      gnt0 = 1'b0;
      gnt1 = 1'b0;
    end
  end

  assign req0_ready = gnt0;
  assign req1_ready = gnt1;
  assign beat_lock  = gnt0 ? req0_lock : req1_lock;
  assign cnt_inc    = cnt_q + 1'b1;

  // Accepted beat goes straight to the RAM; the port is zeroed when no beat.
  always_comb begin
    ram_addr = '0;
    ram_we   = 1'b0;
    ram_din  = '0;
    if (gnt0) begin
      ram_addr = req0_addr;
      ram_we   = req0_we;
      ram_din  = req0_wdata;
    end else if (gnt1) begin
      ram_addr = req1_addr;
      ram_we   = req1_we;
      ram_din  = req1_wdata;
    end
  end

  always_comb begin
    state_d      = state_q;
    last_grant_d = last_grant_q;
    cnt_d        = cnt_q;
    resp_d       = {gnt1 & ~req1_we, gnt0 & ~req0_we};
    if (gnt0 | gnt1) begin
      last_grant_d = gnt1;
      if (state_q == IDLE) begin
        // MAX_LOCK of 1 means a lock request can never extend past its first beat.
        if (beat_lock && (MAX_LOCK_C != 1'b1)) begin
          state_d = gnt0 ? LOCK0 : LOCK1;
          cnt_d   = 1'b1;
        end
      end else if (!beat_lock || (cnt_inc == MAX_LOCK_C)) begin
        state_d = IDLE;
        cnt_d   = '0;
      end else begin
        cnt_d = cnt_inc;
      end
    end
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      state_q      <= IDLE;
      last_grant_q <= 1'b1;
      cnt_q        <= '0;
      resp_q       <= '0;
    end else begin
      state_q      <= state_d;
      last_grant_q <= last_grant_d;
      cnt_q        <= cnt_d;
      resp_q       <= resp_d;
    end
  end

  // ram_dout is only meaningful in the cycle after a read; elsewhere force zero.
  assign resp0_valid = resp_q[0] & ~reset;
  assign resp1_valid = resp_q[1] & ~reset;
  assign resp0_data  = resp0_valid ? ram_dout : '0;
  assign resp1_data  = resp1_valid ? ram_dout : '0;

`ifdef DPRAM_ARB_STATS_EN
  logic [STATS_W-1:0] stat_grant0_q, stat_grant0_d;
  logic [STATS_W-1:0] stat_grant1_q, stat_grant1_d;
  logic [STATS_W-1:0] stat_stall_q,  stat_stall_d;
  logic               stall;

  assign stall = (req0_valid & ~gnt0) | (req1_valid & ~gnt1);

  // Saturating counters: hold at all-ones.
  always_comb begin
    stat_grant0_d = stat_grant0_q;
    stat_grant1_d = stat_grant1_q;
    stat_stall_d  = stat_stall_q;
    if (gnt0 && (stat_grant0_q != '1)) stat_grant0_d = stat_grant0_q + 1'b1;
    if (gnt1 && (stat_grant1_q != '1)) stat_grant1_d = stat_grant1_q + 1'b1;
    if (stall && (stat_stall_q != '1)) stat_stall_d  = stat_stall_q + 1'b1;
  end

  always_ff @(posedge clock or posedge reset) begin
    if (reset) begin
      stat_grant0_q <= '0;
      stat_grant1_q <= '0;
      stat_stall_q  <= '0;
    end else begin
      stat_grant0_q <= stat_grant0_d;
      stat_grant1_q <= stat_grant1_d;
      stat_stall_q  <= stat_stall_d;
    end
  end

  assign stat_grant0 = stat_grant0_q;
  assign stat_grant1 = stat_grant1_q;
  assign stat_stall  = stat_stall_q;
`endif

endmodule

// File: tb/tb_dpram_port_arbiter.sv
// Purpose     : self-checking bench for dpram_port_arbiter against a rule-level model.
// Latency     : n/a.
// Backpressure: n/a.
module tb_dpram_port_arbiter;

  localparam int DW = 32;
  localparam int NE = 64;
  localparam int AW = 6;
  localparam int ML = 4;

  logic          clock = 1'b0;
  logic          reset;
  logic          req0_valid, req0_ready, req0_we, req0_lock;
  logic [AW-1:0] req0_addr;
  logic [DW-1:0] req0_wdata;
  logic          req1_valid, req1_ready, req1_we, req1_lock;
  logic [AW-1:0] req1_addr;
  logic [DW-1:0] req1_wdata;
  logic          resp0_valid, resp1_valid;
  logic [DW-1:0] resp0_data, resp1_data;
  logic [AW-1:0] ram_addr;
  logic          ram_we;
  logic [DW-1:0] ram_din, ram_dout;
`ifdef DPRAM_ARB_STATS_EN
  logic [31:0]   stat_grant0, stat_grant1, stat_stall;
`endif

  always #5 clock = ~clock;

  dpram_port_arbiter #(
    .DATA_WIDTH (DW),
    .NUM_ENTRIES(NE),
    .ADDR_WIDTH (AW),
    .MAX_LOCK   (ML)
  ) dut (
    .clock      (clock),
    .reset      (reset),
    .req0_valid (req0_valid),
    .req0_ready (req0_ready),
    .req0_we    (req0_we),
    .req0_lock  (req0_lock),
    .req0_addr  (req0_addr),
    .req0_wdata (req0_wdata),
    .req1_valid (req1_valid),
    .req1_ready (req1_ready),
    .req1_we    (req1_we),
    .req1_lock  (req1_lock),
    .req1_addr  (req1_addr),
    .req1_wdata (req1_wdata),
    .resp0_valid(resp0_valid),
    .resp0_data (resp0_data),
    .resp1_valid(resp1_valid),
    .resp1_data (resp1_data),
    .ram_addr   (ram_addr),
    .ram_we     (ram_we),
    .ram_din    (ram_din),
    .ram_dout   (ram_dout)
`ifdef DPRAM_ARB_STATS_EN
    ,
    .stat_grant0(stat_grant0),
    .stat_grant1(stat_grant1),
    .stat_stall (stat_stall)
`endif
  );

  // 1-cycle-latency RAM, no_change write mode: dout holds during writes.
  logic [DW-1:0] ram_mem [NE];
  always @(posedge clock) begin
    if (ram_we) ram_mem[ram_addr] <= ram_din;
    else        ram_dout          <= ram_mem[ram_addr];
  end

  int n_cmp = 0;
  int n_err = 0;

  task automatic check(input string tag, input logic [63:0] obs, input logic [63:0] exp);
    n_cmp++;
    if (obs !== exp) begin
      n_err++;
      $display("FAIL %s: got %0h, expected %0h", tag, obs, exp);
    end
  endtask

  // Reference model: who owns the port, who won last, what each address holds.
  int            m_owner;   // -1 = free arbitration
  int            m_beats;
  int            m_last;
  logic [DW-1:0] m_mem   [NE];
  bit            m_known [NE];
  bit            e_rv0, e_rv1, e_rk0, e_rk1;
  logic [DW-1:0] e_rd0, e_rd1;
  int            m_g0, m_g1, m_st;
  int            last_g;
  logic [DW-1:0] s_rd0, s_rd1;
  logic          s_rv0, s_rv1;

  task automatic set_req(input int n, input bit v, input bit we, input bit lk,
                         input int a, input logic [DW-1:0] d);
    if (n == 0) begin
      req0_valid = v; req0_we = we; req0_lock = lk; req0_addr = AW'(a); req0_wdata = d;
    end else begin
      req1_valid = v; req1_we = we; req1_lock = lk; req1_addr = AW'(a); req1_wdata = d;
    end
  endtask

  task automatic idle_inputs();
    set_req(0, 0, 0, 0, 0, '0);
    set_req(1, 0, 0, 0, 0, '0);
  endtask

  // Called at posedge+1 with inputs set; returns at the next posedge+1.
  task automatic step();
    int g;
    bit lk;
    #1;
    g = -1;
    if (m_owner >= 0) begin
      if ((m_owner == 0 && req0_valid) || (m_owner == 1 && req1_valid)) g = m_owner;
    end else if (req0_valid && req1_valid) g = (m_last == 0) ? 1 : 0;
    else if (req0_valid) g = 0;
    else if (req1_valid) g = 1;

    s_rv0 = resp0_valid; s_rd0 = resp0_data;
    s_rv1 = resp1_valid; s_rd1 = resp1_data;
    check("ready0", 64'(req0_ready), 64'(g == 0));
    check("ready1", 64'(req1_ready), 64'(g == 1));
    check("resp0_valid", 64'(resp0_valid), 64'(e_rv0));
    check("resp1_valid", 64'(resp1_valid), 64'(e_rv1));
    if (!e_rv0) check("resp0_data_zero", 64'(resp0_data), 64'd0);
    else if (e_rk0) check("resp0_data", 64'(resp0_data), 64'(e_rd0));
    if (!e_rv1) check("resp1_data_zero", 64'(resp1_data), 64'd0);
    else if (e_rk1) check("resp1_data", 64'(resp1_data), 64'(e_rd1));
    if (g == 0) begin
      check("ram_we", 64'(ram_we), 64'(req0_we));
      check("ram_addr", 64'(ram_addr), 64'(req0_addr));
      check("ram_din", 64'(ram_din), 64'(req0_wdata));
    end else if (g == 1) begin
      check("ram_we", 64'(ram_we), 64'(req1_we));
      check("ram_addr", 64'(ram_addr), 64'(req1_addr));
      check("ram_din", 64'(ram_din), 64'(req1_wdata));
    end else begin
      check("ram_we_idle", 64'(ram_we), 64'd0);
      check("ram_addr_idle", 64'(ram_addr), 64'd0);
      check("ram_din_idle", 64'(ram_din), 64'd0);
    end
`ifdef DPRAM_ARB_STATS_EN
    check("stat_grant0", 64'(stat_grant0), 64'(m_g0));
    check("stat_grant1", 64'(stat_grant1), 64'(m_g1));
    check("stat_stall", 64'(stat_stall), 64'(m_st));
`endif

    // Advance the model by the beat accepted this cycle.
    e_rv0 = 0; e_rv1 = 0;
    if ((req0_valid && g != 0) || (req1_valid && g != 1)) m_st++;
    if (g >= 0) begin
      if (g == 0) begin
        m_g0++;
        lk = req0_lock;
        if (req0_we) begin m_mem[req0_addr] = req0_wdata; m_known[req0_addr] = 1; end
        else begin e_rv0 = 1; e_rd0 = m_mem[req0_addr]; e_rk0 = m_known[req0_addr]; end
      end else begin
        m_g1++;
        lk = req1_lock;
        if (req1_we) begin m_mem[req1_addr] = req1_wdata; m_known[req1_addr] = 1; end
        else begin e_rv1 = 1; e_rd1 = m_mem[req1_addr]; e_rk1 = m_known[req1_addr]; end
      end
      m_last = g;
      if (m_owner < 0) begin
        if (lk && ML > 1) begin m_owner = g; m_beats = 1; end
      end else begin
        m_beats++;
        if (!lk || m_beats >= ML) begin m_owner = -1; m_beats = 0; end
      end
    end
    last_g = g;
    @(posedge clock);
    #1;
  endtask

  // Asserted mid-cycle with both requesters pushing; released one cycle later.
  task automatic do_reset();
    reset = 1'b1;
    set_req(0, 1, 0, 1, 3, '0);
    set_req(1, 1, 1, 1, 4, 32'h1234);
    #1;
    check("rst_ready0", 64'(req0_ready), 64'd0);
    check("rst_ready1", 64'(req1_ready), 64'd0);
    check("rst_ram_we", 64'(ram_we), 64'd0);
    check("rst_resp0_valid", 64'(resp0_valid), 64'd0);
    check("rst_resp1_valid", 64'(resp1_valid), 64'd0);
`ifdef DPRAM_ARB_STATS_EN
    check("rst_stat_grant0", 64'(stat_grant0), 64'd0);
    check("rst_stat_grant1", 64'(stat_grant1), 64'd0);
    check("rst_stat_stall", 64'(stat_stall), 64'd0);
`endif
    m_owner = -1; m_beats = 0; m_last = 1;
    e_rv0 = 0; e_rv1 = 0;
    m_g0 = 0; m_g1 = 0; m_st = 0;
    @(posedge clock);
    #1;
    reset = 1'b0;
    idle_inputs();
  endtask

  int grants[5];
  int exp_029[4] = '{0, 1, 0, 1};
  int exp_030[4] = '{0, 0, 0, 1};
  int exp_031[5] = '{0, 0, 0, 0, 1};

  initial begin
    reset = 1'b1;
    idle_inputs();
    for (int i = 0; i < NE; i++) m_known[i] = 0;
    m_owner = -1; m_beats = 0; m_last = 1;
    e_rv0 = 0; e_rv1 = 0; e_rk0 = 0; e_rk1 = 0;
    m_g0 = 0; m_g1 = 0; m_st = 0;
    @(posedge clock);
    #1;
    do_reset();

    // Write then read back address 5; also seed addresses 1 and 2.
    set_req(0, 1, 1, 0, 5, 32'hDEADBEEF); step();
    set_req(0, 1, 0, 0, 5, '0);           step();
    set_req(0, 1, 1, 0, 1, 32'h0000_1111); step();
    check("r28_resp0_valid", 64'(s_rv0), 64'd1);
    check("r28_resp0_data", 64'(s_rd0), 64'hDEADBEEF);
    check("r28_resp1_valid", 64'(s_rv1), 64'd0);
    set_req(0, 1, 1, 0, 2, 32'h0000_2222); step();
    idle_inputs(); step();

    // Both read continuously from a fresh reset: strict alternation.
    do_reset();
    for (int i = 0; i < 4; i++) begin
      set_req(0, 1, 0, 0, 1, '0);
      set_req(1, 1, 0, 0, 2, '0);
      step();
      grants[i] = last_g;
    end
    idle_inputs(); step();
    for (int i = 0; i < 4; i++) check($sformatf("r29_grant%0d", i), 64'(grants[i]), 64'(exp_029[i]));
`ifdef DPRAM_ARB_STATS_EN
    check("r33_grant0", 64'(stat_grant0), 64'd2);
    check("r33_grant1", 64'(stat_grant1), 64'd2);
    check("r33_stall", 64'(stat_stall), 64'd4);
`endif

    // 3-beat locked write burst from req0 while req1 waits.
    for (int i = 0; i < 4; i++) begin
      set_req(0, i < 3, 1, i < 2, 10 + i, 32'hA000 + i);
      set_req(1, 1, 0, 0, 10, '0);
      step();
      grants[i] = last_g;
    end
    idle_inputs(); step();
    for (int i = 0; i < 4; i++) check($sformatf("r30_grant%0d", i), 64'(grants[i]), 64'(exp_030[i]));

    // req0 keeps lock high; forced release after ML beats.
    for (int i = 0; i < 5; i++) begin
      set_req(0, 1, 1, 1, 20 + i, 32'hB000 + i);
      set_req(1, 1, 0, 0, 20, '0);
      step();
      grants[i] = last_g;
    end
    idle_inputs(); step();
    for (int i = 0; i < 5; i++) check($sformatf("r31_grant%0d", i), 64'(grants[i]), 64'(exp_031[i]));

    // Reset right after an accepted read drops its response.
    set_req(0, 1, 0, 0, 5, '0); step();
    do_reset();
    set_req(0, 1, 0, 0, 5, '0);
    set_req(1, 1, 0, 0, 1, '0);
    step();
    check("r32_first_after_reset", 64'(last_g), 64'd0);
    idle_inputs(); step();

    // Reset in the middle of a req1 lock frees the port for req0.
    set_req(1, 1, 1, 1, 30, 32'hC0DE); step();
    do_reset();
    set_req(0, 1, 0, 0, 30, '0); step();
    check("r23_unlock", 64'(last_g), 64'd0);
    idle_inputs(); step();

    // Randomized mix of reads, writes, locks and occasional resets.
    for (int c = 0; c < 3000; c++) begin
      if ($urandom_range(0, 299) == 0) begin
        do_reset();
      end else begin
        set_req(0, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom);
        set_req(1, $urandom_range(0, 3) != 0, $urandom_range(0, 1) == 1,
                $urandom_range(0, 2) != 0, $urandom_range(0, 15), $urandom);
        step();
      end
    end
    idle_inputs(); step();

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_err);
    $finish;
  end

endmodule
